// File: rtl/sensor_tx_scheduler.sv
// Shares one 80-bit UART TX channel between ADS1292 samples and MPR121 touch updates.
// Each source has a one-deep buffer. A round-robin arbiter feeds a two-state frame sender.
module sensor_tx_scheduler #(
  parameter int         DROP_CNT_W = 8,
  parameter logic [3:0] ADS_TAG    = 4'hA,
  parameter logic [3:0] MPR_TAG    = 4'hB
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTN,
  input  logic                  i_RUN,
  input  logic [71:0]           i_ADS_DATA,
  input  logic                  i_ADS_VALID,
  input  logic [11:0]           i_MPR_STATUS,
  input  logic                  i_MPR_VALID,
  output logic [79:0]           o_UART_DATA_TX,
  output logic                  o_UART_DATA_TX_VALID,
  input  logic                  i_UART_DATA_TX_READY,
  output logic [DROP_CNT_W-1:0] o_ADS_DROP_CNT,
  output logic [DROP_CNT_W-1:0] o_MPR_DROP_CNT,
  output logic                  o_BUSY
);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_SEND = 1'b1;

  logic        state;
  logic        ads_full;
  logic        mpr_full;
  logic [71:0] ads_buf;
  logic [11:0] mpr_buf;
  logic [3:0]  ads_seq;
  logic [3:0]  mpr_seq;
  logic        last_mpr;
  logic        grant_ads;
  logic        grant_mpr;
  logic        ads_drop;
  logic        mpr_drop;

  // last_mpr is the round-robin pointer: on a tie, the source not granted last wins
  always_comb begin
    grant_ads = 1'b0;
    grant_mpr = 1'b0;
    if (state == STATE_IDLE && i_RUN) begin
      if (ads_full && (!mpr_full || last_mpr))
        grant_ads = 1'b1;
      else if (mpr_full)
        grant_mpr = 1'b1;
    end
  end

  assign ads_drop = i_RUN & i_ADS_VALID & ads_full & ~grant_ads;
  assign mpr_drop = i_RUN & i_MPR_VALID & mpr_full & ~grant_mpr;
  assign o_BUSY   = (state == STATE_SEND) | ads_full | mpr_full;

  // A buffer being emptied by a grant can take a new sample in the same cycle
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      ads_full <= 1'b0;
      mpr_full <= 1'b0;
      ads_buf  <= '0;
      mpr_buf  <= '0;
    end else if (!i_RUN) begin
      ads_full <= 1'b0;
      mpr_full <= 1'b0;
    end else begin
      if (i_ADS_VALID && (!ads_full || grant_ads)) begin
        ads_buf  <= i_ADS_DATA;
        ads_full <= 1'b1;
      end else if (grant_ads) begin
        ads_full <= 1'b0;
      end
      if (i_MPR_VALID && (!mpr_full || grant_mpr)) begin
        mpr_buf  <= i_MPR_STATUS;
        mpr_full <= 1'b1;
      end else if (grant_mpr) begin
        mpr_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      o_ADS_DROP_CNT <= '0;
      o_MPR_DROP_CNT <= '0;
    end else begin
      if (ads_drop && o_ADS_DROP_CNT != '1)
        o_ADS_DROP_CNT <= o_ADS_DROP_CNT + DROP_CNT_W'(1);
      if (mpr_drop && o_MPR_DROP_CNT != '1)
        o_MPR_DROP_CNT <= o_MPR_DROP_CNT + DROP_CNT_W'(1);
    end
  end

  // The frame register is only loaded in IDLE, so it stays stable while waiting for ready
  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state                <= STATE_IDLE;
      o_UART_DATA_TX       <= 80'h0;
      o_UART_DATA_TX_VALID <= 1'b0;
      ads_seq              <= 4'h0;
      mpr_seq              <= 4'h0;
      last_mpr             <= 1'b1;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (grant_ads) begin
            o_UART_DATA_TX       <= {ADS_TAG, ads_seq, ads_buf};
            o_UART_DATA_TX_VALID <= 1'b1;
            ads_seq              <= ads_seq + 4'h1;
            last_mpr             <= 1'b0;
            state                <= STATE_SEND;
          end else if (grant_mpr) begin
            o_UART_DATA_TX       <= {MPR_TAG, mpr_seq, 60'h0, mpr_buf};
            o_UART_DATA_TX_VALID <= 1'b1;
            mpr_seq              <= mpr_seq + 4'h1;
            last_mpr             <= 1'b1;
            state                <= STATE_SEND;
          end
        end
        STATE_SEND: begin
          if (i_UART_DATA_TX_READY) begin
            o_UART_DATA_TX_VALID <= 1'b0;
            state                <= STATE_IDLE;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_tx_scheduler.sv
// Scoreboard bench for sensor_tx_scheduler: expected frames are queued when stimulus is driven
// and compared when the UART handshake completes.
module tb_sensor_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [71:0] ads_data;
  logic        ads_valid;
  logic [11:0] mpr_status;
  logic        mpr_valid;
  logic [79:0] uart_data;
  logic        uart_valid;
  logic        uart_ready;
  logic [7:0]  ads_drop;
  logic [7:0]  mpr_drop;
  logic        busy;

  int          errors = 0;
  int          checks = 0;
  logic [79:0] exp_q[$];
  logic [79:0] mon_exp;

  sensor_tx_scheduler #(.DROP_CNT_W(8), .ADS_TAG(4'hA), .MPR_TAG(4'hB)) dut (
    .i_CLK                (clk),
    .i_RSTN               (rst_n),
    .i_RUN                (run),
    .i_ADS_DATA           (ads_data),
    .i_ADS_VALID          (ads_valid),
    .i_MPR_STATUS         (mpr_status),
    .i_MPR_VALID          (mpr_valid),
    .o_UART_DATA_TX       (uart_data),
    .o_UART_DATA_TX_VALID (uart_valid),
    .i_UART_DATA_TX_READY (uart_ready),
    .o_ADS_DROP_CNT       (ads_drop),
    .o_MPR_DROP_CNT       (mpr_drop),
    .o_BUSY               (busy)
  );

  always #20 clk = ~clk;

  // Every accepted frame is checked against the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && uart_valid && uart_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL frame_unexpected got=%h expected=none", uart_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (uart_data !== mon_exp) begin
          errors++;
          $display("[TB] FAIL frame_data got=%h expected=%h", uart_data, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    run        = 1'b0;
    ads_data   = '0;
    ads_valid  = 1'b0;
    mpr_status = '0;
    mpr_valid  = 1'b0;
    uart_ready = 1'b0;
    tick();
    tick();
    exp_q.delete();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_ads(input logic [71:0] d);
    ads_data  = d;
    ads_valid = 1'b1;
    tick();
    ads_valid = 1'b0;
  endtask

  task automatic pulse_mpr(input logic [11:0] s);
    mpr_status = s;
    mpr_valid  = 1'b1;
    tick();
    mpr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain pending=%0d expected=0", name, exp_q.size());
    end
  endtask

  task automatic sample_valid(output logic [5:0] pattern);
    pattern = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pattern[i] = uart_valid;
    end
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run = 1'b0; ads_valid = 1'b0; mpr_valid = 1'b0; uart_ready = 1'b0;
    ads_data = '0; mpr_status = '0;
    #3;
    checks++;
    if ({uart_data, uart_valid, ads_drop, mpr_drop, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%h/%b/%h/%h/%b expected=all zero",
               uart_data, uart_valid, ads_drop, mpr_drop, busy);
    end
    apply_reset();
    checks++;
    if (uart_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release valid=%b busy=%b expected=0/0", uart_valid, busy);
    end
  endtask

  task automatic test_single_ads();
    logic [5:0] pat;
    apply_reset();
    run = 1'b1;
    uart_ready = 1'b1;
    exp_q.push_back(80'hA0_0123456789ABCDEF01);
    pulse_ads(72'h0123456789ABCDEF01);
    sample_valid(pat);
    checks++;
    if (pat !== 6'b000010) begin
      errors++;
      $display("[TB] FAIL single_valid_pattern got=%b expected=%b", pat, 6'b000010);
    end
    check8("single_mpr_drop", mpr_drop, 8'h00);
    wait_drain("single");
  endtask

  task automatic test_simultaneous();
    logic [5:0] pat;
    apply_reset();
    run = 1'b1;
    uart_ready = 1'b1;
    exp_q.push_back({8'hA0, 72'h1122334455667788AA});
    exp_q.push_back(80'hB0_000000000000000805);
    ads_data = 72'h1122334455667788AA;
    mpr_status = 12'h805;
    ads_valid = 1'b1;
    mpr_valid = 1'b1;
    tick();
    ads_valid = 1'b0;
    mpr_valid = 1'b0;
    sample_valid(pat);
    checks++;
    if (pat !== 6'b001010) begin
      errors++;
      $display("[TB] FAIL simul_valid_pattern got=%b expected=%b", pat, 6'b001010);
    end
    check8("simul_ads_drop", ads_drop, 8'h00);
    check8("simul_mpr_drop", mpr_drop, 8'h00);
    wait_drain("simul");
  endtask

  task automatic test_back_to_back_backpressure();
    logic [79:0] f1;
    bit stable;
    apply_reset();
    run = 1'b1;
    uart_ready = 1'b0;
    f1 = {8'hA0, 72'hAAAA_0000_0000_0000_01};
    exp_q.push_back(f1);
    exp_q.push_back({8'hA1, 72'hBBBB_0000_0000_0000_02});
    pulse_ads(72'hAAAA_0000_0000_0000_01);
    repeat (3) tick();
    pulse_ads(72'hBBBB_0000_0000_0000_02);
    repeat (3) tick();
    pulse_ads(72'hCCCC_0000_0000_0000_03);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_valid !== 1'b1 || uart_data !== f1) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("[TB] FAIL bp_hold got=%b/%h expected=1/%h", uart_valid, uart_data, f1);
    end
    check8("bp_ads_drop", ads_drop, 8'h01);
    check8("bp_busy", {7'h0, busy}, 8'h01);
    uart_ready = 1'b1;
    wait_drain("bp");
    repeat (3) tick();
    check8("bp_idle_busy", {7'h0, busy}, 8'h00);
  endtask

  task automatic test_seq_wrap();
    logic [11:0] s;
    apply_reset();
    run = 1'b1;
    uart_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      s = 12'(i * 37 + 1);
      exp_q.push_back({4'hB, 4'(i), 60'h0, s});
      pulse_mpr(s);
      repeat (4) tick();
    end
    wait_drain("wrap");
  endtask

  task automatic test_saturation();
    apply_reset();
    run = 1'b1;
    uart_ready = 1'b0;
    for (int i = 0; i < 256; i++) pulse_ads(72'(i));
    check8("sat_before", ads_drop, 8'hFE);
    for (int i = 0; i < 44; i++) pulse_ads(72'(i));
    check8("sat_ads_drop", ads_drop, 8'hFF);
    check8("sat_mpr_drop", mpr_drop, 8'h00);
  endtask

  task automatic test_run_gating();
    int vcount;
    apply_reset();
    run = 1'b1;
    uart_ready = 1'b0;
    exp_q.push_back({8'hA0, 72'h0000_0000_0000_00D1});
    pulse_ads(72'h0000_0000_0000_00D1);
    repeat (2) tick();
    pulse_ads(72'h0000_0000_0000_00D2);
    tick();
    run = 1'b0;
    repeat (2) tick();
    pulse_ads(72'h0000_0000_0000_00D3);
    pulse_mpr(12'h0F0);
    tick();
    check8("gate_ads_drop", ads_drop, 8'h00);
    check8("gate_mpr_drop", mpr_drop, 8'h00);
    check8("gate_pending_valid", {7'h0, uart_valid}, 8'h01);
    uart_ready = 1'b1;
    wait_drain("gate");
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (uart_valid) vcount++;
    end
    check8("gate_no_more_frames", 8'(vcount), 8'h00);
    check8("gate_busy", {7'h0, busy}, 8'h00);
  endtask

  task automatic test_reset_mid_send();
    apply_reset();
    run = 1'b1;
    uart_ready = 1'b0;
    pulse_ads(72'h0000_0000_0000_0E01);
    repeat (2) tick();
    pulse_ads(72'h0000_0000_0000_0E02);
    pulse_ads(72'h0000_0000_0000_0E03);
    check8("rst_pre_valid", {7'h0, uart_valid}, 8'h01);
    check8("rst_pre_drop", ads_drop, 8'h01);
    #5;
    rst_n = 1'b0;
    #1;
    checks++;
    if (uart_valid !== 1'b0 || busy !== 1'b0 || ads_drop !== 8'h00 || uart_data !== 80'h0) begin
      errors++;
      $display("[TB] FAIL rst_async got=%b/%b/%h/%h expected=0/0/00/0",
               uart_valid, busy, ads_drop, uart_data);
    end
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    uart_ready = 1'b1;
    exp_q.push_back({8'hA0, 72'h0000_0000_0000_0E04});
    pulse_ads(72'h0000_0000_0000_0E04);
    wait_drain("rst_seq");
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_ads();
    test_simultaneous();
    test_back_to_back_backpressure();
    test_seq_wrap();
    test_saturation();
    test_run_gating();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
